// File: rtl/regfile_pkg.sv
// Shared constants and sizing helpers for the multi-ported register file.
// Optional same-cycle write forwarding is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int CONF_W     = 16;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_NREGS  = 32;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Width of a write-port index; at least one bit even with a single port.
    function automatic int sel_w(input int nports);
        return (nports > 1) ? clog2(nports) : 1;
    endfunction

endpackage

// File: rtl/rf_wr_arb.sv
// Write-port arbitration: per-register hit, winning port (highest index) and collision flag.
// Register 0 never hits, so it can never win or collide.
module rf_wr_arb
    import regfile_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int NWR   = 2,
    localparam int AW   = clog2(NREGS),
    localparam int IW   = sel_w(NWR)
) (
    input  logic [NWR-1:0]      WE,
    input  logic [NWR*AW-1:0]   WA,
    output logic [NREGS-1:0]    hit,
    output logic [NREGS*IW-1:0] win,
    output logic [NREGS-1:0]    coll
);

    always_comb begin
        hit  = '0;
        win  = '0;
        coll = '0;
        for (int r = 1; r < NREGS; r++) begin
            // Ascending scan: a later enabled port overwrites the winner.
            for (int j = 0; j < NWR; j++) begin
                if (WE[j] && (WA[j*AW +: AW] == AW'(r))) begin
                    if (hit[r]) coll[r] = 1'b1;
                    hit[r]           = 1'b1;
                    win[r*IW +: IW]  = IW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/mp_regfile.sv
// Multi-ported register file with busy scoreboard and write-collision monitor.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module mp_regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREGS  = DEF_NREGS,
    parameter int NRD    = 4,
    parameter int NWR    = 2,
    localparam int AW    = clog2(NREGS)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NRD*AW-1:0]     RA,
    output logic [NRD*DATA_W-1:0] RD,
    output logic [NRD-1:0]        RBUSY,
    input  logic [NWR-1:0]        WE,
    input  logic [NWR*AW-1:0]     WA,
    input  logic [NWR*DATA_W-1:0] WD,
    input  logic                  RSV_EN,
    input  logic [AW-1:0]         RSV_A,
    output logic                  WCONF,
    output logic [CONF_W-1:0]     CONF_CNT
);

    localparam int IW = sel_w(NWR);
    localparam logic [CONF_W-1:0] CONF_MAX = '1;

    logic [DATA_W-1:0] mem     [NREGS];
    logic [DATA_W-1:0] wr_data [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  hit;
    logic [NREGS*IW-1:0] win;
    logic [NREGS-1:0]  coll_a;
    logic              coll;

    rf_wr_arb #(
        .NREGS (NREGS),
        .NWR   (NWR)
    ) u_arb (
        .WE   (WE),
        .WA   (WA),
        .hit  (hit),
        .win  (win),
        .coll (coll_a)
    );

    assign coll = |coll_a;

    // Data presented by the winning port for each register.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            wr_data[r] = WD[int'(win[r*IW +: IW])*DATA_W +: DATA_W];
        end
    end

    // Register 0 is never written and busy[0] is never set, so it stays zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int r = 0; r < NREGS; r++) mem[r] <= '0;
            busy     <= '0;
            WCONF    <= 1'b0;
            CONF_CNT <= '0;
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (hit[r]) mem[r] <= wr_data[r];
                if (RSV_EN && (RSV_A == AW'(r))) busy[r] <= 1'b1;
                else if (hit[r])                 busy[r] <= 1'b0;
            end
            WCONF <= coll;
            if (coll && (CONF_CNT != CONF_MAX)) CONF_CNT <= CONF_CNT + CONF_W'(1);
        end
    end

    always_comb begin
        RD    = '0;
        RBUSY = '0;
        for (int i = 0; i < NRD; i++) begin
            logic [AW-1:0] ra;
            ra = RA[i*AW +: AW];
            RD[i*DATA_W +: DATA_W] = mem[ra];
            RBUSY[i] = (ra != '0) && busy[ra];
`ifdef REGFILE_BYPASS_EN
            // A pending write completes the register, so it only looks busy if re-reserved now.
            if (hit[ra]) begin
                RD[i*DATA_W +: DATA_W] = wr_data[ra];
                RBUSY[i] = RSV_EN && (RSV_A == ra);
            end
`endif
        end
    end

endmodule

// File: tb/tb_mp_regfile.sv
// Directed plus randomized bench for mp_regfile; expected values queue up as stimulus is driven.
module tb_mp_regfile;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int AW  = 5;
    localparam int NRD = 4;
    localparam int NWR = 2;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                CLK;
    logic                RST;
    logic [NRD*AW-1:0]   RA;
    logic [NRD*DW-1:0]   RD;
    logic [NRD-1:0]      RBUSY;
    logic [NWR-1:0]      WE;
    logic [NWR*AW-1:0]   WA;
    logic [NWR*DW-1:0]   WD;
    logic                RSV_EN;
    logic [AW-1:0]       RSV_A;
    logic                WCONF;
    logic [15:0]         CONF_CNT;

    logic [DW-1:0] exp_q[$];
    int n_asserts = 0;
    int n_fail    = 0;

    mp_regfile #(
        .DATA_W (DW),
        .NREGS  (NR),
        .NRD    (NRD),
        .NWR    (NWR)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .RA       (RA),
        .RD       (RD),
        .RBUSY    (RBUSY),
        .WE       (WE),
        .WA       (WA),
        .WD       (WD),
        .RSV_EN   (RSV_EN),
        .RSV_A    (RSV_A),
        .WCONF    (WCONF),
        .CONF_CNT (CONF_CNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        WE     = '0;
        RSV_EN = 1'b0;
    endtask

    task automatic set_ra(input int i, input logic [AW-1:0] a);
        RA[i*AW +: AW] = a;
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        WE[p]          = 1'b1;
        WA[p*AW +: AW] = a;
        WD[p*DW +: DW] = d;
    endtask

    function automatic logic [DW-1:0] rd_of(input int i);
        return RD[i*DW +: DW];
    endfunction

    task automatic push(input logic [DW-1:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs);
        logic [DW-1:0] exp_v;
        n_asserts++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %h, expected queue empty", tag, obs);
        end else begin
            exp_v = exp_q.pop_front();
            assert (obs === exp_v) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
            end
        end
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [DW-1:0] d;
        int p;
        int rp;

        RST = 1'b1; RA = '0; WE = '0; WA = '0; WD = '0; RSV_EN = 1'b0; RSV_A = '0;
        #2;
        set_ra(0, 5);
        #1;
        push(0); check("reset_rd", rd_of(0));
        push(0); check("reset_conf_cnt", 32'(CONF_CNT));
        push(0); check("reset_wconf", 32'(WCONF));
        push(0); check("reset_rbusy", 32'(RBUSY));
        tick(); tick();
        RST = 1'b0;
        tick();

        // Asynchronous reset mid-cycle wipes stored data at once.
        wr(0, 5, 32'hDEADBEEF);
        push(32'hDEADBEEF);
        tick(); idle(); #1;
        check("wr_r5", rd_of(0));
        #2; RST = 1'b1; #1;
        push(0); check("async_rst_rd", rd_of(0));
        push(0); check("async_rst_conf", 32'(CONF_CNT));

        // Write held across reset release: ignored under reset, commits on first edge after.
        wr(0, 6, 32'h12345678); set_ra(0, 6);
        tick();
        push(0); check("rst_ignores_wr", rd_of(0));
        RST = 1'b0;
        push(32'h12345678);
        tick(); idle(); #1;
        check("first_commit", rd_of(0));

        // Collision on r7: highest port wins, one-cycle WCONF pulse.
        wr(0, 7, 32'h11); wr(1, 7, 32'h22); set_ra(0, 7);
        push(32'h22); push(1); push(1);
        tick(); idle(); #1;
        check("coll_rd", rd_of(0));
        check("coll_wconf", 32'(WCONF));
        check("coll_cnt", 32'(CONF_CNT));
        push(0); push(1);
        tick();
        check("coll_wconf_drop", 32'(WCONF));
        check("coll_cnt_hold", 32'(CONF_CNT));

        // Two ports, distinct addresses: no collision.
        wr(0, 8, 32'h88); wr(1, 9, 32'h99);
        push(32'h88); push(32'h99); push(0);
        tick(); idle(); set_ra(0, 8); set_ra(1, 9); #1;
        check("dual_rd8", rd_of(0));
        check("dual_rd9", rd_of(1));
        check("dual_wconf", 32'(WCONF));

        // Reserve r3, then observe busy on two ports, then clear by writing.
        RSV_EN = 1'b1; RSV_A = 3;
        tick(); idle(); set_ra(0, 3); set_ra(2, 3); #1;
        push(1); check("rsv_busy0", 32'(RBUSY[0]));
        push(1); check("rsv_busy2", 32'(RBUSY[2]));
        push(0); check("rsv_rd2", rd_of(2));
        wr(0, 3, 32'h55); #1;
        push(BYP ? 32'd0 : 32'd1); check("busy_same_cycle", 32'(RBUSY[0]));
        tick(); idle(); #1;
        push(0); check("busy_cleared", 32'(RBUSY[0]));
        push(32'h55); check("busy_wr_rd", rd_of(0));
        push(0); check("busy_cleared2", 32'(RBUSY[2]));

        // Reserve and write to r4 in the same cycle: data lands, busy stays set.
        RSV_EN = 1'b1; RSV_A = 4; wr(0, 4, 32'h9); set_ra(0, 4); #1;
        push(BYP ? 32'd1 : 32'd0); check("rsv_wr_busy_now", 32'(RBUSY[0]));
        tick(); idle(); #1;
        push(32'h9); check("rsv_wr_rd", rd_of(0));
        push(1); check("rsv_wr_busy", 32'(RBUSY[0]));

        // r0 is hardwired: writes dropped, never busy, never a collision.
        wr(0, 0, 32'hFFFFFFFF); wr(1, 0, 32'hFFFFFFFF); RSV_EN = 1'b1; RSV_A = 0; set_ra(0, 0);
        tick(); idle(); #1;
        push(0); check("r0_rd", rd_of(0));
        push(0); check("r0_busy", 32'(RBUSY[0]));
        push(0); check("r0_wconf", 32'(WCONF));
        push(1); check("r0_cnt", 32'(CONF_CNT));

        // Same-cycle read of a register being written.
        set_ra(1, 9); wr(0, 9, 32'hABCD); #1;
        push(BYP ? 32'hABCD : 32'h99); check("bypass_rd1", rd_of(1));
        tick(); idle(); #1;
        push(32'hABCD); check("bypass_after", rd_of(1));

        set_ra(3, 10); wr(0, 10, 32'h1); wr(1, 10, 32'h2); #1;
        push(BYP ? 32'h2 : 32'h0); check("bypass_coll_rd3", rd_of(3));
        tick(); idle(); #1;
        push(32'h2); check("coll2_rd3", rd_of(3));
        push(1); check("coll2_wconf", 32'(WCONF));
        push(2); check("coll2_cnt", 32'(CONF_CNT));

        // Randomized single-port writes read back through a random read port.
        for (int k = 0; k < 16; k++) begin
            ra = AW'($urandom_range(11, NR - 1));
            d  = $urandom;
            p  = $urandom_range(0, NWR - 1);
            rp = $urandom_range(0, NRD - 1);
            wr(p, ra, d);
            push(d);
            tick(); idle(); set_ra(rp, ra); #1;
            check("rand_rd", rd_of(rp));
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
